// File: rtl/io_cycle_seq.sv
// io_cycle_seq: I/O bus-cycle sequencer for the 120 CPU board.
// Turns CPU AS/DS cycles into RDIO_n/WRIO_n, returns DTACK_n or BERR_n.
module io_cycle_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic AS_n,
  input  logic UDS_n,
  input  logic LDS_n,
  input  logic RW,
  input  logic IOSEL,
  input  logic IOACK_n,
  output logic RDIO_n,
  output logic WRIO_n,
  output logic DTACK_n,
  output logic BERR_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_ACK,
    S_BERR
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic r_as_meta;
  logic r_as_s;
  logic r_uds_meta;
  logic r_uds_s;
  logic r_lds_meta;
  logic r_lds_s;
  logic r_rw_meta;
  logic r_rw_s;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd;
  logic             r_wr;
  logic             r_dt;
  logic             r_be;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_rd_nx;
  logic             w_wr_nx;
  logic             w_dt_nx;
  logic             w_be_nx;
  logic             w_ds_s;
  logic             w_start;

  // Preset to 1 so a reset never looks like an active strobe.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_as_meta  <= 1'b1;
      r_as_s     <= 1'b1;
      r_uds_meta <= 1'b1;
      r_uds_s    <= 1'b1;
      r_lds_meta <= 1'b1;
      r_lds_s    <= 1'b1;
      r_rw_meta  <= 1'b1;
      r_rw_s     <= 1'b1;
    end else begin
      r_as_meta  <= AS_n;
      r_as_s     <= r_as_meta;
      r_uds_meta <= UDS_n;
      r_uds_s    <= r_uds_meta;
      r_lds_meta <= LDS_n;
      r_lds_s    <= r_lds_meta;
      r_rw_meta  <= RW;
      r_rw_s     <= r_rw_meta;
    end
  end

  assign w_ds_s  = r_uds_s & r_lds_s;
  assign w_start = ~r_as_s & ~w_ds_s & IOSEL;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rd_nx    = r_rd;
    w_wr_nx    = r_wr;
    w_dt_nx    = r_dt;
    w_be_nx    = r_be;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nx = S_STROBE;
          w_cnt_nx   = '0;
          w_rd_nx    = ~r_rw_s;
          w_wr_nx    = r_rw_s;
        end
      end
      S_STROBE: begin
        if (r_cnt != C_MAX) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
        // Abort beats acknowledge, acknowledge beats timeout.
        if (r_as_s) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_rd_nx    = 1'b1;
          w_wr_nx    = 1'b1;
        end else if (!IOACK_n) begin
          w_state_nx = S_ACK;
          w_dt_nx    = 1'b0;
        end else if (r_cnt == C_LAST) begin
          w_state_nx = S_BERR;
          w_be_nx    = 1'b0;
          w_rd_nx    = 1'b1;
          w_wr_nx    = 1'b1;
        end
      end
      S_ACK: begin
        if (r_as_s) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_dt_nx    = 1'b1;
          w_rd_nx    = 1'b1;
          w_wr_nx    = 1'b1;
        end
      end
      S_BERR: begin
        if (r_as_s) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_be_nx    = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_rd_nx    = 1'b1;
        w_wr_nx    = 1'b1;
        w_dt_nx    = 1'b1;
        w_be_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b1;
      r_wr    <= 1'b1;
      r_dt    <= 1'b1;
      r_be    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_rd    <= w_rd_nx;
      r_wr    <= w_wr_nx;
      r_dt    <= w_dt_nx;
      r_be    <= w_be_nx;
    end
  end

  assign RDIO_n  = r_rd;
  assign WRIO_n  = r_wr;
  assign DTACK_n = r_dt;
  assign BERR_n  = r_be;

endmodule

// File: tb/tb_io_cycle_seq.sv
// tb_io_cycle_seq: directed bench for io_cycle_seq.
// Bus-cycle model checked every cycle plus literal timing points.
module tb_io_cycle_seq;

  localparam int TMO = 16;

  logic CLK     = 1'b0;
  logic RESET_n = 1'b0;
  logic AS_n    = 1'b1;
  logic UDS_n   = 1'b1;
  logic LDS_n   = 1'b1;
  logic RW      = 1'b1;
  logic IOSEL   = 1'b0;
  logic IOACK_n = 1'b1;
  logic RDIO_n;
  logic WRIO_n;
  logic DTACK_n;
  logic BERR_n;

  int n_chk = 0;
  int n_err = 0;

  io_cycle_seq #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .AS_n(AS_n),
    .UDS_n(UDS_n),
    .LDS_n(LDS_n),
    .RW(RW),
    .IOSEL(IOSEL),
    .IOACK_n(IOACK_n),
    .RDIO_n(RDIO_n),
    .WRIO_n(WRIO_n),
    .DTACK_n(DTACK_n),
    .BERR_n(BERR_n)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Bus-cycle model: pins reach the sequencer two edges late.
  localparam int P_IDLE = 0;
  localparam int P_STR  = 1;
  localparam int P_ACK  = 2;
  localparam int P_ERR  = 3;

  logic [1:0] h_as  = 2'b11;
  logic [1:0] h_uds = 2'b11;
  logic [1:0] h_lds = 2'b11;
  logic [1:0] h_rw  = 2'b11;
  int   m_phase = P_IDLE;
  int   m_age   = 0;
  logic m_rd    = 1'b1;
  logic m_wr    = 1'b1;
  logic m_dt    = 1'b1;
  logic m_be    = 1'b1;
  logic m_as;
  logic m_ds;
  logic m_rw;

  initial forever begin
    @(posedge CLK or negedge RESET_n);
    if (!RESET_n) begin
      h_as = 2'b11; h_uds = 2'b11; h_lds = 2'b11; h_rw = 2'b11;
      m_phase = P_IDLE; m_age = 0;
      m_rd = 1; m_wr = 1; m_dt = 1; m_be = 1;
    end else begin
      m_as = h_as[1];
      m_ds = h_uds[1] & h_lds[1];
      m_rw = h_rw[1];
      if (m_phase == P_IDLE) begin
        if (!m_as && !m_ds && IOSEL) begin
          m_phase = P_STR; m_age = 0;
          m_rd = ~m_rw; m_wr = m_rw;
        end
      end else if (m_phase == P_STR) begin
        m_age++;
        if (m_as) begin
          m_phase = P_IDLE; m_rd = 1; m_wr = 1;
        end else if (!IOACK_n) begin
          m_phase = P_ACK; m_dt = 0;
        end else if (m_age == TMO) begin
          m_phase = P_ERR; m_be = 0; m_rd = 1; m_wr = 1;
        end
      end else if (m_phase == P_ACK) begin
        if (m_as) begin
          m_phase = P_IDLE; m_dt = 1; m_rd = 1; m_wr = 1;
        end
      end else begin
        if (m_as) begin
          m_phase = P_IDLE; m_be = 1;
        end
      end
      h_as  = {h_as[0], AS_n};
      h_uds = {h_uds[0], UDS_n};
      h_lds = {h_lds[0], LDS_n};
      h_rw  = {h_rw[0], RW};
    end
  end

  always @(negedge CLK) begin
    chk1("m_rdio", RDIO_n, m_rd);
    chk1("m_wrio", WRIO_n, m_wr);
    chk1("m_dtack", DTACK_n, m_dt);
    chk1("m_berr", BERR_n, m_be);
    chk1("inv_strobes", RDIO_n | WRIO_n, 1'b1);
    chk1("inv_resp", DTACK_n | BERR_n, 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_idle();
    AS_n = 1; UDS_n = 1; LDS_n = 1; IOACK_n = 1;
  endtask

  initial begin
    step(2);
    chk1("rst_rd", RDIO_n, 1'b1);
    chk1("rst_wr", WRIO_n, 1'b1);
    chk1("rst_dt", DTACK_n, 1'b1);
    chk1("rst_be", BERR_n, 1'b1);
    RESET_n = 1;
    step(3);

    // read cycle, ack three cycles after the strobe
    IOSEL = 1; RW = 1; UDS_n = 0; AS_n = 0;
    step(2);
    chk1("rd_edge1", RDIO_n, 1'b1);
    step(1);
    chk1("rd_edge2", RDIO_n, 1'b0);
    chk1("rd_wr_hi", WRIO_n, 1'b1);
    step(2);
    chk1("rd_pre_ack", DTACK_n, 1'b1);
    IOACK_n = 0;
    step(1);
    chk1("rd_dtack", DTACK_n, 1'b0);
    IOACK_n = 1; AS_n = 1; UDS_n = 1;
    step(2);
    chk1("rd_dt_hold", DTACK_n, 1'b0);
    chk1("rd_rd_hold", RDIO_n, 1'b0);
    step(1);
    chk1("rd_dt_rel", DTACK_n, 1'b1);
    chk1("rd_rd_rel", RDIO_n, 1'b1);
    step(3);

    // write cycle of TOD length: ack twelve edges after strobe
    RW = 0; LDS_n = 0; AS_n = 0;
    step(3);
    chk1("wr_strobe", WRIO_n, 1'b0);
    chk1("wr_rd_hi", RDIO_n, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(1);
      chk1("wr_wait_dt", DTACK_n, 1'b1);
      chk1("wr_wait_wr", WRIO_n, 1'b0);
    end
    IOACK_n = 0;
    step(1);
    chk1("wr_dtack", DTACK_n, 1'b0);
    chk1("wr_no_berr", BERR_n, 1'b1);
    bus_idle();
    step(3);
    chk1("wr_rel", WRIO_n, 1'b1);
    step(2);

    // timeout
    RW = 1; UDS_n = 0; AS_n = 0;
    step(3);
    chk1("to_strobe", RDIO_n, 1'b0);
    step(TMO - 1);
    chk1("to_pre_be", BERR_n, 1'b1);
    chk1("to_pre_rd", RDIO_n, 1'b0);
    step(1);
    chk1("to_berr", BERR_n, 1'b0);
    chk1("to_rd_rel", RDIO_n, 1'b1);
    chk1("to_no_dt", DTACK_n, 1'b1);
    IOACK_n = 0;
    step(2);
    chk1("to_late_ack", DTACK_n, 1'b1);
    bus_idle();
    step(2);
    chk1("to_be_hold", BERR_n, 1'b0);
    step(1);
    chk1("to_be_rel", BERR_n, 1'b1);
    step(2);

    // ack on the timeout edge
    RW = 1; UDS_n = 0; AS_n = 0;
    step(3 + TMO - 1);
    IOACK_n = 0;
    step(1);
    chk1("sim_dt", DTACK_n, 1'b0);
    chk1("sim_be", BERR_n, 1'b1);
    chk1("sim_rd", RDIO_n, 1'b0);
    bus_idle();
    step(3);
    chk1("sim_rel", DTACK_n, 1'b1);
    step(2);

    // CPU abort mid-strobe
    RW = 0; LDS_n = 0; AS_n = 0;
    step(3);
    chk1("ab_strobe", WRIO_n, 1'b0);
    step(3);
    AS_n = 1; LDS_n = 1;
    step(2);
    chk1("ab_hold", WRIO_n, 1'b0);
    step(1);
    chk1("ab_rel", WRIO_n, 1'b1);
    step(20);
    chk1("ab_no_be", BERR_n, 1'b1);
    chk1("ab_no_dt", DTACK_n, 1'b1);

    // non-I/O cycle
    IOSEL = 0; RW = 1; UDS_n = 0; AS_n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk1("nio_rd", RDIO_n, 1'b1);
    end
    bus_idle(); IOSEL = 1;
    step(3);

    // back-to-back with a single AS_n-high cycle
    RW = 1; UDS_n = 0; AS_n = 0;
    step(3);
    chk1("bb1_rd", RDIO_n, 1'b0);
    IOACK_n = 0;
    step(1);
    chk1("bb1_dt", DTACK_n, 1'b0);
    AS_n = 1; UDS_n = 1; IOACK_n = 1;
    step(1);
    AS_n = 0; UDS_n = 0;
    step(1);
    chk1("bb1_dt_hold", DTACK_n, 1'b0);
    step(1);
    chk1("bb_gap_dt", DTACK_n, 1'b1);
    chk1("bb_gap_rd", RDIO_n, 1'b1);
    step(1);
    chk1("bb2_rd", RDIO_n, 1'b0);
    chk1("bb2_dt_hi", DTACK_n, 1'b1);
    IOACK_n = 0;
    step(1);
    chk1("bb2_dt", DTACK_n, 1'b0);
    bus_idle();
    step(3);
    chk1("bb2_rel", DTACK_n, 1'b1);
    step(2);

    // reset while acknowledged
    RW = 1; UDS_n = 0; AS_n = 0;
    step(3);
    IOACK_n = 0;
    step(1);
    chk1("rs_dt_pre", DTACK_n, 1'b0);
    chk1("rs_rd_pre", RDIO_n, 1'b0);
    RESET_n = 0;
    #1;
    chk1("rs_dt_async", DTACK_n, 1'b1);
    chk1("rs_rd_async", RDIO_n, 1'b1);
    chkv("rs_cnt", int'(dut.r_cnt), 0);
    bus_idle();
    step(2);
    RESET_n = 1;
    step(2);
    RW = 1; UDS_n = 0; AS_n = 0;
    step(2);
    chk1("rs2_edge1", RDIO_n, 1'b1);
    step(1);
    chk1("rs2_edge2", RDIO_n, 1'b0);
    IOACK_n = 0;
    step(1);
    chk1("rs2_dt", DTACK_n, 1'b0);
    bus_idle();
    step(3);
    chk1("rs2_rel", DTACK_n, 1'b1);
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
